// File: rtl/floppy_mfm_writer.sv
// floppy_mfm_writer: serialises one floppy record as MFM flux pulses.
// The record is a preamble of 0x00 bytes, three A1 sync marks, the caller's
// byte stream and a CCITT CRC-16. Each data bit becomes a clock cell and a
// data cell. Every cell lasts clkspd/(2*bitrate) clocks. A cell of value 1
// drives o_WrPulse high for the first PULSE_CLKS clocks of that cell.
// Optional feature macro: FLOPPY_WR_POSTAMBLE_EN adds four 0x4E gap bytes
// after the CRC, with the write gate still held.
module floppy_mfm_writer #(
  parameter int clkspd     = 25000000,
  parameter int bitrate    = 250000,
  parameter int PREAMBLE   = 12,
  parameter int PULSE_CLKS = 6
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Start,
  input  logic [7:0] i_Data,
  input  logic       i_Valid,
  input  logic       i_Last,
  output logic       o_Ready,
  output logic       o_WrPulse,
  output logic       o_WrGate,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_Underrun
);

  localparam int CELL_CLKS = clkspd / (2 * bitrate);
  localparam int CW        = (CELL_CLKS > 1) ? $clog2(CELL_CLKS) : 1;
  localparam int BW        = $clog2(PREAMBLE + 4) + 1;

  localparam logic [CW-1:0] CELL_LAST  = CW'(CELL_CLKS - 1);
  localparam logic [CW-1:0] PULSE_HOLD = CW'(PULSE_CLKS - 1);
  localparam logic [BW-1:0] PRE_LAST   = BW'(PREAMBLE - 1);
  localparam logic [15:0]   SYNC_CELLS = 16'h4489;  // A1 with its missing clock
  localparam logic [15:0]   ZERO_CELLS = 16'hAAAA;  // 0x00 after a 0 bit

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_SYNC     = 3'd2,
    S_DATA     = 3'd3,
    S_CRC_HI   = 3'd4,
    S_CRC_LO   = 3'd5,
    S_POST     = 3'd6
  } state_t;

  // MFM cells for one byte, MSB first; the clock cell precedes each data cell.
  function automatic logic [15:0] mfm_byte(input logic [7:0] d, input logic p);
    logic [15:0] r;
    logic        prev;
    r    = 16'h0000;
    prev = p;
    for (int i = 7; i >= 0; i--) begin
      r[2*i+1] = ~(prev | d[i]);
      r[2*i]   = d[i];
      prev     = d[i];
    end
    return r;
  endfunction

  // CRC-16 CCITT (poly 0x1021, MSB first) advanced by one byte.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0};
      if (fb) begin
        r = r ^ 16'h1021;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  state_t      state_r;
  logic [15:0] shift_r;
  logic [CW-1:0] clk_cnt_r;
  logic [3:0]  cell_idx_r;
  logic [BW-1:0] byte_cnt_r;
  logic        prev_r;
  logic [15:0] crc_r;
  logic [7:0]  hold_data_r;
  logic        hold_full_r;
  logic        hold_last_r;
  logic        last_acc_r;
  logic        cur_last_r;
  logic        pulse_r;
  logic        gate_r;
  logic        busy_r;
  logic        done_r;
  logic        underrun_r;

  logic        ready_s;
  logic        accept_s;
  logic [15:0] data_cells_s;
  logic [15:0] crc_hi_cells_s;
  logic [15:0] crc_lo_cells_s;
  logic [15:0] post_cells_s;
  logic [15:0] crc_a1_s;
  logic [15:0] crc_data_s;

  // Next-byte cell patterns, CRC updates and the holding-register handshake.
  always_comb begin
    ready_s        = ((state_r == S_SYNC) || (state_r == S_DATA)) && !hold_full_r && !last_acc_r;
    accept_s       = ready_s && i_Valid;
    data_cells_s   = mfm_byte(hold_data_r, prev_r);
    crc_hi_cells_s = mfm_byte(crc_r[15:8], prev_r);
    crc_lo_cells_s = mfm_byte(crc_r[7:0], prev_r);
    post_cells_s   = mfm_byte(8'h4E, prev_r);
    crc_a1_s       = crc16_byte(crc_r, 8'hA1);
    crc_data_s     = crc16_byte(crc_r, hold_data_r);
  end

  // Record sequencer: cell timing, byte scheduling, CRC and holding register.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_r     <= S_IDLE;
      shift_r     <= 16'h0000;
      clk_cnt_r   <= '0;
      cell_idx_r  <= 4'd0;
      byte_cnt_r  <= '0;
      prev_r      <= 1'b0;
      crc_r       <= 16'hFFFF;
      hold_data_r <= 8'h00;
      hold_full_r <= 1'b0;
      hold_last_r <= 1'b0;
      last_acc_r  <= 1'b0;
      cur_last_r  <= 1'b0;
      pulse_r     <= 1'b0;
      gate_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      underrun_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept_s) begin
        hold_data_r <= i_Data;
        hold_full_r <= 1'b1;
        hold_last_r <= i_Last;
        last_acc_r  <= i_Last;
      end
      case (state_r)
        S_IDLE: begin
          pulse_r <= 1'b0;
          if (i_Start) begin
            state_r     <= S_PREAMBLE;
            busy_r      <= 1'b1;
            gate_r      <= 1'b1;
            underrun_r  <= 1'b0;
            crc_r       <= 16'hFFFF;
            shift_r     <= ZERO_CELLS;
            pulse_r     <= ZERO_CELLS[15];
            prev_r      <= 1'b0;
            clk_cnt_r   <= '0;
            cell_idx_r  <= 4'd0;
            byte_cnt_r  <= '0;
            hold_full_r <= 1'b0;
            hold_last_r <= 1'b0;
            last_acc_r  <= 1'b0;
            cur_last_r  <= 1'b0;
          end
        end
        S_PREAMBLE, S_SYNC, S_DATA, S_CRC_HI, S_CRC_LO, S_POST: begin
          if (clk_cnt_r != CELL_LAST) begin
            clk_cnt_r <= clk_cnt_r + CW'(1);
            pulse_r   <= pulse_r & (clk_cnt_r < PULSE_HOLD);
          end else begin
            clk_cnt_r <= '0;
            if (cell_idx_r != 4'd15) begin
              cell_idx_r <= cell_idx_r + 4'd1;
              shift_r    <= {shift_r[14:0], 1'b0};
              pulse_r    <= shift_r[14];
            end else begin
              // Byte boundary: pick the next 16 cells.
              cell_idx_r <= 4'd0;
              case (state_r)
                S_PREAMBLE: begin
                  if (byte_cnt_r == PRE_LAST) begin
                    state_r    <= S_SYNC;
                    byte_cnt_r <= '0;
                    shift_r    <= SYNC_CELLS;
                    pulse_r    <= SYNC_CELLS[15];
                    crc_r      <= crc_a1_s;
                    prev_r     <= 1'b1;
                  end else begin
                    byte_cnt_r <= byte_cnt_r + BW'(1);
                    shift_r    <= ZERO_CELLS;
                    pulse_r    <= ZERO_CELLS[15];
                  end
                end
                S_SYNC, S_DATA: begin
                  if ((state_r == S_SYNC) && (byte_cnt_r != BW'(2))) begin
                    byte_cnt_r <= byte_cnt_r + BW'(1);
                    shift_r    <= SYNC_CELLS;
                    pulse_r    <= SYNC_CELLS[15];
                    crc_r      <= crc_a1_s;
                  end else if ((state_r == S_DATA) && cur_last_r) begin
                    state_r <= S_CRC_HI;
                    shift_r <= crc_hi_cells_s;
                    pulse_r <= crc_hi_cells_s[15];
                    prev_r  <= crc_r[8];
                  end else if (hold_full_r) begin
                    state_r     <= S_DATA;
                    shift_r     <= data_cells_s;
                    pulse_r     <= data_cells_s[15];
                    crc_r       <= crc_data_s;
                    prev_r      <= hold_data_r[0];
                    hold_full_r <= 1'b0;
                    cur_last_r  <= hold_last_r;
                  end else begin
                    // Starved: the byte just sent stands, no CRC follows.
                    state_r    <= S_IDLE;
                    busy_r     <= 1'b0;
                    gate_r     <= 1'b0;
                    done_r     <= 1'b1;
                    pulse_r    <= 1'b0;
                    underrun_r <= 1'b1;
                  end
                end
                S_CRC_HI: begin
                  state_r <= S_CRC_LO;
                  shift_r <= crc_lo_cells_s;
                  pulse_r <= crc_lo_cells_s[15];
                  prev_r  <= crc_r[0];
                end
`ifdef FLOPPY_WR_POSTAMBLE_EN
                S_CRC_LO: begin
                  state_r    <= S_POST;
                  byte_cnt_r <= '0;
                  shift_r    <= post_cells_s;
                  pulse_r    <= post_cells_s[15];
                  prev_r     <= 1'b0;
                end
                S_POST: begin
                  if (byte_cnt_r != BW'(3)) begin
                    byte_cnt_r <= byte_cnt_r + BW'(1);
                    shift_r    <= post_cells_s;
                    pulse_r    <= post_cells_s[15];
                    prev_r     <= 1'b0;
                  end else begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    gate_r  <= 1'b0;
                    done_r  <= 1'b1;
                    pulse_r <= 1'b0;
                  end
                end
`endif
                default: begin
                  // Last CRC cell (or an unreachable state): close the record.
                  state_r <= S_IDLE;
                  busy_r  <= 1'b0;
                  gate_r  <= 1'b0;
                  done_r  <= 1'b1;
                  pulse_r <= 1'b0;
                end
              endcase
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          gate_r  <= 1'b0;
          pulse_r <= 1'b0;
        end
      endcase
    end
  end

  assign o_Ready    = ready_s;
  assign o_WrPulse  = pulse_r;
  assign o_WrGate   = gate_r;
  assign o_Busy     = busy_r;
  assign o_Done     = done_r;
  assign o_Underrun = underrun_r;

endmodule

// File: tb/tb_floppy_mfm_writer.sv
// Bench for floppy_mfm_writer. The stimulus pushes the expected decoded bytes
// and the per-record results into queues. A monitor decodes the flux pulses
// cell by cell and checks them against those queues.
module tb_floppy_mfm_writer;

  localparam int CLKSPD  = 2000000;
  localparam int BITRATE = 250000;
  localparam int PRE     = 12;
  localparam int PULSE   = 2;
  localparam int CELL    = 4;  // CLKSPD / (2 * BITRATE)

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       last = 1'b0;
  logic       ready, wr_pulse, wr_gate, busy, done, underrun;

  floppy_mfm_writer #(
    .clkspd(CLKSPD), .bitrate(BITRATE), .PREAMBLE(PRE), .PULSE_CLKS(PULSE)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Start(start), .i_Data(data),
    .i_Valid(valid), .i_Last(last), .o_Ready(ready), .o_WrPulse(wr_pulse),
    .o_WrGate(wr_gate), .o_Busy(busy), .o_Done(done), .o_Underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] b;
    logic       sync;
  } exp_t;

  exp_t exp_q[$];
  int   len_q[$];
  logic ur_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   rec_cnt = 0;
  int   done_seen = 0;
  bit   skip = 1'b0;

  logic [7:0] payload [5] = '{8'hFE, 8'h00, 8'h00, 8'h01, 8'h02};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic push_byte(input logic [7:0] b, input logic s);
    exp_t e;
    e.b = b;
    e.sync = s;
    exp_q.push_back(e);
  endtask

  task automatic push_head();
    for (int i = 0; i < PRE; i++) push_byte(8'h00, 1'b0);
    for (int i = 0; i < 3; i++) push_byte(8'hA1, 1'b1);
  endtask

  // Full record: FE 00 00 01 02, CRC over A1 A1 A1 + payload is CA 6F.
  task automatic push_std();
    push_head();
    for (int i = 0; i < 5; i++) push_byte(payload[i], 1'b0);
    push_byte(8'hCA, 1'b0);
    push_byte(8'h6F, 1'b0);
`ifdef FLOPPY_WR_POSTAMBLE_EN
    for (int i = 0; i < 4; i++) push_byte(8'h4E, 1'b0);
    len_q.push_back(16 * (PRE + 3 + 5 + 2) + 64);
`else
    len_q.push_back(16 * (PRE + 3 + 5 + 2));
`endif
    ur_q.push_back(1'b0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    data = d; valid = 1'b1; last = l;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    valid = 1'b0; last = 1'b0;
    if (!ok) begin
      n_total++;
      $display("FAIL send_byte: byte 0x%0h never accepted, expected acceptance", d);
    end
  endtask

  task automatic send_payload();
    for (int i = 0; i < 5; i++) send_byte(payload[i], (i == 4) ? 1'b1 : 1'b0);
  endtask

  task automatic wait_rec(input int target);
    for (int i = 0; i < 4000 && rec_cnt < target; i++) @(posedge clk);
    #1;
    check("record_complete", rec_cnt, target);
  endtask

  // Monitor: decodes cells, checks pulse shape/spacing and record framing.
  initial begin : monitor
    int cc, cells, viol, shape, last_pc, phase;
    logic cellbit, in_rec;
    logic [15:0] word;
    logic [7:0] dec;
    exp_t e;
    in_rec = 1'b0; cc = 0; cells = 0; viol = 0; shape = 0; last_pc = -1;
    cellbit = 1'b0; word = 16'h0000;
    forever begin
      @(negedge clk);
      if (done) done_seen++;
      if (wr_gate) begin
        if (!in_rec) begin
          in_rec = 1'b1; cc = 0; cells = 0; viol = 0; shape = 0; last_pc = -1;
          word = 16'h0000;
        end
        phase = cc % CELL;
        if (phase == 0) begin
          cellbit = wr_pulse;
          word = {word[14:0], wr_pulse};
          if (wr_pulse) begin
            if (last_pc >= 0 && (cc - last_pc) != 8 && (cc - last_pc) != 12 && (cc - last_pc) != 16)
              viol++;
            last_pc = cc;
          end
        end
        if (wr_pulse !== (cellbit && (phase < PULSE))) shape++;
        if (done) shape++;
        if (phase == CELL - 1) begin
          cells++;
          if ((cells % 16) == 0 && !skip) begin
            dec = {word[14], word[12], word[10], word[8], word[6], word[4], word[2], word[0]};
            if (exp_q.size() == 0) begin
              n_total++;
              $display("FAIL unexpected_byte: got 0x%0h, expected no more bytes", dec);
            end else begin
              e = exp_q.pop_front();
              check("decoded_byte", dec, e.b);
              if (e.sync) check("sync_cells", word, 16'h4489);
            end
          end
        end
        cc++;
      end else if (in_rec) begin
        in_rec = 1'b0;
        if (!skip) begin
          if (len_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_record: got %0d cells, expected none", cells);
          end else begin
            check("record_cells", cells, len_q.pop_front());
            check("underrun_flag", underrun, ur_q.pop_front());
          end
          check("done_at_end", done, 1);
          check("busy_low_at_end", busy, 0);
          check("bytes_left", exp_q.size(), 0);
          check("pulse_spacing_errs", viol, 0);
          check("pulse_shape_errs", shape, 0);
          rec_cnt++;
        end
      end
    end
  end

  initial begin : stimulus
    bit seen;
    repeat (3) @(posedge clk); #1;
    check("reset_outputs", {wr_pulse, wr_gate, busy, done, underrun, ready}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of the preamble.
    skip = 1'b1;
    pulse_start();
    repeat (40) @(posedge clk); #1;
    check("pre_abort_active", {busy, wr_gate}, 2'b11);
    #2 rst_n = 1'b0;
    #1 check("abort_async_low", {wr_gate, wr_pulse, busy, done}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("abort_idle", {busy, wr_gate, ready}, 0);
    skip = 1'b0;

    // Record 1: standard payload.
    push_std();
    pulse_start();
    check("start_busy_gate", {busy, wr_gate}, 2'b11);
    send_payload();
    check("ready_after_last", ready, 0);
    wait_rec(1);
    check("no_underrun", underrun, 0);

    // Record 2: extra i_Start pulses while busy must be ignored.
    push_std();
    pulse_start();
    repeat (30) @(posedge clk); #1;
    pulse_start();
    send_payload();
    repeat (20) @(posedge clk); #1;
    pulse_start();
    wait_rec(2);

    // Record 3: payload stalls after two bytes.
    push_head();
    push_byte(8'h11, 1'b0);
    push_byte(8'h22, 1'b0);
    len_q.push_back(16 * (PRE + 3 + 2));
    ur_q.push_back(1'b1);
    pulse_start();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("underrun_done_seen", seen, 1);
    check("underrun_set", underrun, 1);

    // Record 4: start in the same cycle as o_Done, clears o_Underrun.
    #1;
    push_std();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy", busy, 1);
    check("underrun_cleared", underrun, 0);
    send_payload();
    wait_rec(4);

    repeat (5) @(posedge clk); #1;
    check("done_pulse_count", done_seen, 4);
    check("records_total", rec_cnt, 4);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
